key_debouncer: RTL and testbench

Input conditioning stage that sits directly upstream of the LED counter and the other DE-board demo datapaths. It takes the raw, asynchronous, active-low pushbuttons KEY[N-1:0] and synchronises each one to CLOCK_50. It then debounces each key with a per-key state machine. For every key it produces a clean pressed level, single-cycle press and release pulses, and a press-toggled level, suitable as enable or clear inputs to downstream counters.

---
 rtl/key_debouncer.sv | 119 +++++++++++
 tb/tb_key_debouncer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debouncer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | key_debouncer: synchronises and debounces active-low pushbuttons into    |
// | clean levels, press/release strobes and a press-toggled level per key.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module key_debouncer #(
   parameter int NKEYS           = 4,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic             CLOCK_50,
   input  logic             Resetn,
   input  logic [NKEYS-1:0] KEY,
   output logic [NKEYS-1:0] pressed,
   output logic [NKEYS-1:0] press_pulse,
   output logic [NKEYS-1:0] release_pulse,
   output logic [NKEYS-1:0] toggle
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] C_CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_RELEASED        = 2'd0,
      S_PRESS_PENDING   = 2'd1,
      S_PRESSED         = 2'd2,
      S_RELEASE_PENDING = 2'd3
   } state_t;

   generate
      for (genvar k = 0; k < NKEYS; k++) begin : g_key
         logic          r_meta;
         logic          r_sync;
         logic          w_ks;
         logic [CW-1:0] r_cnt;
         state_t        r_state;
         logic          r_pressed;
         logic          r_press_pulse;
         logic          r_release_pulse;
         logic          r_toggle;

         // Flops hold the raw active-low level, so reset loads "released".
         always_ff @(posedge CLOCK_50) begin
            if (!Resetn) begin
               r_meta <= 1'b1;
               r_sync <= 1'b1;
            end else begin
               r_meta <= KEY[k];
               r_sync <= r_meta;
            end
         end

         assign w_ks = ~r_sync;

         always_ff @(posedge CLOCK_50) begin
            if (!Resetn) begin
               r_state         <= S_RELEASED;
               r_cnt           <= '0;
               r_pressed       <= 1'b0;
               r_press_pulse   <= 1'b0;
               r_release_pulse <= 1'b0;
               r_toggle        <= 1'b0;
            end else begin
               r_press_pulse   <= 1'b0;
               r_release_pulse <= 1'b0;

               // Any agreement restarts the count; reaching the last value means acceptance.
               if ((w_ks == r_pressed) || (r_cnt == C_CNT_LAST)) begin
                  r_cnt <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end

               case (r_state)
                  S_RELEASED: begin
                     if (w_ks) begin
                        r_state <= S_PRESS_PENDING;
                     end
                  end
                  S_PRESS_PENDING: begin
                     if (!w_ks) begin
                        r_state <= S_RELEASED;
                     end else if (r_cnt == C_CNT_LAST) begin
                        r_state       <= S_PRESSED;
                        r_pressed     <= 1'b1;
                        r_press_pulse <= 1'b1;
                        r_toggle      <= ~r_toggle;
                     end
                  end
                  S_PRESSED: begin
                     if (!w_ks) begin
                        r_state <= S_RELEASE_PENDING;
                     end
                  end
                  S_RELEASE_PENDING: begin
                     if (w_ks) begin
                        r_state <= S_PRESSED;
                     end else if (r_cnt == C_CNT_LAST) begin
                        r_state         <= S_RELEASED;
                        r_pressed       <= 1'b0;
                        r_release_pulse <= 1'b1;
                     end
                  end
                  default: begin
                     r_state <= S_RELEASED;
                  end
               endcase
            end
         end

         assign pressed[k]       = r_pressed;
         assign press_pulse[k]   = r_press_pulse;
         assign release_pulse[k] = r_release_pulse;
         assign toggle[k]        = r_toggle;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_key_debouncer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_key_debouncer: directed and randomized checks of key_debouncer        |
// | against a sliding-window reference model. Revision: 1.0                  |
// +--------------------------------------------------------------------------+
module tb_key_debouncer;
   localparam int NK = 4;
   localparam int DB = 4;

   logic          CLOCK_50 = 1'b0;
   logic          Resetn;
   logic [NK-1:0] KEY;
   logic [NK-1:0] pressed;
   logic [NK-1:0] press_pulse;
   logic [NK-1:0] release_pulse;
   logic [NK-1:0] toggle;

   int checks = 0;
   int fails  = 0;

   always #10 CLOCK_50 = ~CLOCK_50;

   key_debouncer #(.NKEYS(NK), .DEBOUNCE_CYCLES(DB)) dut (
      .CLOCK_50      (CLOCK_50),
      .Resetn        (Resetn),
      .KEY           (KEY),
      .pressed       (pressed),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .toggle        (toggle)
   );

   // Reference: a change is accepted when the last DB synchronised samples
   // all disagree with the current debounced level.
   logic [NK-1:0] m_meta, m_sync, m_pressed, m_pp, m_rp, m_tog;
   logic [DB-1:0] m_hist [NK];

   always @(posedge CLOCK_50) begin : ref_model
      logic [DB-1:0] h;
      logic          acc;
      for (int k = 0; k < NK; k++) begin
         if (!Resetn) begin
            m_meta[k]    <= 1'b1;
            m_sync[k]    <= 1'b1;
            m_hist[k]    <= '0;
            m_pressed[k] <= 1'b0;
            m_pp[k]      <= 1'b0;
            m_rp[k]      <= 1'b0;
            m_tog[k]     <= 1'b0;
         end else begin
            h   = {m_hist[k][DB-2:0], ~m_sync[k]};
            acc = m_pressed[k] ? (h == '0) : (h == '1);
            m_hist[k] <= h;
            m_pp[k]   <= acc & ~m_pressed[k];
            m_rp[k]   <= acc & m_pressed[k];
            if (acc) m_pressed[k] <= ~m_pressed[k];
            if (acc && !m_pressed[k]) m_tog[k] <= ~m_tog[k];
            m_sync[k] <= m_meta[k];
            m_meta[k] <= KEY[k];
         end
      end
   end

   logic [4*NK-1:0] dut_vec, exp_vec;
   assign dut_vec = {pressed, press_pulse, release_pulse, toggle};
   assign exp_vec = {m_pressed, m_pp, m_rp, m_tog};

   task automatic step();
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
   endtask

   task automatic test_reset();
      Resetn = 1'b0;
      KEY    = '1;
      for (int i = 0; i < 3; i++) step();
      checks++;
      if (dut_vec !== '0) begin
         fails++;
         $display("FAIL reset_outputs: got %h expected 0", dut_vec);
      end
      Resetn = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         checks++;
         if (dut_vec !== '0) begin
            fails++;
            $display("FAIL reset_idle cycle %0d: got %h expected 0", i, dut_vec);
         end
      end
   endtask

   task automatic test_clean_press();
      for (int e = 1; e <= 30; e++) begin
         if (e == 1)  KEY[0] = 1'b0;
         if (e == 20) KEY[0] = 1'b1;
         step();
         checks++;
         if (dut_vec !== exp_vec) begin
            fails++;
            $display("FAIL clean_model edge %0d: got %h expected %h", e, dut_vec, exp_vec);
         end
         if (e == 5) begin
            checks++;
            if (pressed[0] !== 1'b0) begin
               fails++;
               $display("FAIL clean_early edge 5: pressed[0] got %b expected 0", pressed[0]);
            end
         end
         if (e == 6) begin
            checks++;
            if ({pressed[0], press_pulse[0], toggle[0]} !== 3'b111) begin
               fails++;
               $display("FAIL clean_press edge 6: got %b expected 111",
                        {pressed[0], press_pulse[0], toggle[0]});
            end
         end
         if (e == 7) begin
            checks++;
            if ({pressed[0], press_pulse[0]} !== 2'b10) begin
               fails++;
               $display("FAIL clean_pulse_end edge 7: got %b expected 10", {pressed[0], press_pulse[0]});
            end
         end
         if (e == 24) begin
            checks++;
            if ({pressed[0], release_pulse[0]} !== 2'b10) begin
               fails++;
               $display("FAIL clean_rel_early edge 24: got %b expected 10", {pressed[0], release_pulse[0]});
            end
         end
         if (e == 25) begin
            checks++;
            if ({pressed[0], release_pulse[0]} !== 2'b01) begin
               fails++;
               $display("FAIL clean_release edge 25: got %b expected 01", {pressed[0], release_pulse[0]});
            end
         end
      end
   endtask

   task automatic test_bounce();
      int pulses = 0;
      for (int e = 1; e <= 20; e++) begin
         KEY[1] = (e == 4) ? 1'b1 : 1'b0;
         step();
         if (press_pulse[1] === 1'b1) pulses++;
         checks++;
         if (dut_vec !== exp_vec) begin
            fails++;
            $display("FAIL bounce_model edge %0d: got %h expected %h", e, dut_vec, exp_vec);
         end
         // Last falling sample is taken at edge 5, so acceptance lands at 5+DB+1.
         if (e == 9 || e == 10) begin
            checks++;
            if (pressed[1] !== (e == 10)) begin
               fails++;
               $display("FAIL bounce_level edge %0d: got %b expected %b", e, pressed[1], (e == 10));
            end
         end
      end
      checks++;
      if (pulses != 1) begin
         fails++;
         $display("FAIL bounce_pulses: got %0d expected 1", pulses);
      end
      KEY[1] = 1'b1;
      for (int i = 0; i < 10; i++) step();
   endtask

   task automatic test_short_glitch();
      for (int e = 1; e <= 15; e++) begin
         KEY[2] = (e <= 3) ? 1'b0 : 1'b1;
         step();
         checks++;
         if ({pressed[2], press_pulse[2], toggle[2]} !== 3'b000 || dut_vec !== exp_vec) begin
            fails++;
            $display("FAIL glitch edge %0d: got %b/%h expected 000/%h", e,
                     {pressed[2], press_pulse[2], toggle[2]}, dut_vec, exp_vec);
         end
      end
   endtask

   task automatic test_toggle();
      logic [2:0] seen = '0;
      int         n    = 0;
      for (int p = 0; p < 3; p++) begin
         for (int c = 0; c < 16; c++) begin
            KEY[3] = (c < 8) ? 1'b0 : 1'b1;
            step();
            if (press_pulse[3] === 1'b1) begin
               if (n < 3) seen[n] = toggle[3];
               n++;
            end
            checks++;
            if (dut_vec !== exp_vec) begin
               fails++;
               $display("FAIL toggle_model press %0d cycle %0d: got %h expected %h", p, c, dut_vec, exp_vec);
            end
         end
      end
      checks++;
      if (n != 3 || seen !== 3'b101) begin
         fails++;
         $display("FAIL toggle_seq: got %0d pulses seq %b expected 3 pulses seq 101", n, seen);
      end
   endtask

   task automatic test_simultaneous();
      for (int e = 1; e <= 20; e++) begin
         if (e == 1)  KEY[1:0] = 2'b00;
         if (e == 10) KEY[1:0] = 2'b11;
         step();
         checks++;
         if (dut_vec !== exp_vec) begin
            fails++;
            $display("FAIL simul_model edge %0d: got %h expected %h", e, dut_vec, exp_vec);
         end
         if (e >= 5 && e <= 7) begin
            checks++;
            if (press_pulse !== ((e == 6) ? 4'b0011 : 4'b0000)) begin
               fails++;
               $display("FAIL simul_pulse edge %0d: got %b expected %b", e, press_pulse,
                        (e == 6) ? 4'b0011 : 4'b0000);
            end
         end
         if (e == 15) begin
            checks++;
            if (release_pulse !== 4'b0011) begin
               fails++;
               $display("FAIL simul_release edge 15: got %b expected 0011", release_pulse);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      KEY[0] = 1'b0;
      for (int i = 0; i < 3; i++) step();
      Resetn = 1'b0;
      for (int i = 0; i < 2; i++) step();
      checks++;
      if (dut_vec !== '0) begin
         fails++;
         $display("FAIL midreset_outputs: got %h expected 0", dut_vec);
      end
      Resetn = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         step();
         checks++;
         if (dut_vec !== exp_vec) begin
            fails++;
            $display("FAIL midreset_model R+%0d: got %h expected %h", e, dut_vec, exp_vec);
         end
         if (e == 5 || e == 6) begin
            checks++;
            if ({pressed[0], press_pulse[0]} !== ((e == 6) ? 2'b11 : 2'b00)) begin
               fails++;
               $display("FAIL midreset_press R+%0d: got %b expected %b", e,
                        {pressed[0], press_pulse[0]}, (e == 6) ? 2'b11 : 2'b00);
            end
         end
      end
      KEY[0] = 1'b1;
      for (int i = 0; i < 10; i++) step();
   endtask

   task automatic test_random();
      int run [NK];
      int errs = 0;
      for (int k = 0; k < NK; k++) run[k] = 0;
      for (int c = 0; c < 1500; c++) begin
         for (int k = 0; k < NK; k++) begin
            if (run[k] == 0) begin
               KEY[k] = 1'($urandom_range(0, 1));
               run[k] = $urandom_range(1, 12);
            end
            run[k]--;
         end
         if (Resetn == 1'b0) Resetn = 1'b1;
         else if ($urandom_range(0, 299) == 0) Resetn = 1'b0;
         step();
         checks++;
         if (dut_vec !== exp_vec) begin
            fails++;
            errs++;
            if (errs <= 10) $display("FAIL random_model cycle %0d: got %h expected %h", c, dut_vec, exp_vec);
         end
      end
   endtask

   initial begin
      Resetn = 1'b0;
      KEY    = '1;
      test_reset();
      test_clean_press();
      test_bounce();
      test_short_glitch();
      test_toggle();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
`default_nettype wire
